// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_restoring_divider_pkg;

   localparam int unsigned DEF_N_W = 16;
   localparam int unsigned DEF_D_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle between a requester and the divider.
interface seq_restoring_divider_if
   import seq_restoring_divider_pkg::*;
#(
   parameter int unsigned N_W = DEF_N_W,
   parameter int unsigned D_W = DEF_D_W
);
   logic           in_valid;
   logic           in_ready;
   logic [N_W-1:0] dividend;
   logic [D_W-1:0] divisor;
   logic           out_valid;
   logic           out_ready;
   logic [N_W-1:0] quotient;
   logic [D_W-1:0] remainder;
   logic           div_by_zero;
   logic           q_ovf;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, q_ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, q_ovf
   );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
   parameter int unsigned D_W = 8
) (
   input  logic [D_W:0]   r,
   input  logic           dvd_bit,
   input  logic [D_W-1:0] divisor,
   output logic [D_W:0]   r_next,
   output logic           q_bit
);
   logic [D_W:0] t;
   logic         unused_r_msb;

   // A restored partial remainder is always below the divisor, so its MSB is zero.
   assign unused_r_msb = r[D_W];
   assign t            = {r[D_W-1:0], dvd_bit};

   always_comb begin
      r_next = t;
      q_bit  = 1'b0;
      if (t >= {1'b0, divisor}) begin
         r_next = t - {1'b0, divisor};
         q_bit  = 1'b1;
      end
   end
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int unsigned N_W = DEF_N_W,
   parameter int unsigned D_W = DEF_D_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   seq_restoring_divider_if.slave   bus
);
   localparam int unsigned C_W = $clog2(N_W + 1);

   state_t         state, state_nxt;
   logic [N_W-1:0] dvd;
   logic [N_W-2:0] q_sr;
   logic [D_W-1:0] dsr;
   logic [D_W:0]   r, r_nxt;
   logic [C_W-1:0] cnt;
   logic           q_bit;
   logic           accept, last_step;
   logic [N_W-1:0] q_full;

   logic [N_W-1:0] quotient;
   logic [D_W-1:0] remainder;
   logic           div_by_zero, q_ovf;

   div_step #(.D_W(D_W)) u_step (
      .r       (r),
      .dvd_bit (dvd[N_W-1]),
      .divisor (dsr),
      .r_next  (r_nxt),
      .q_bit   (q_bit)
   );

   assign accept    = bus.in_valid && (state == IDLE);
   assign last_step = (cnt == C_W'(N_W - 1));
   assign q_full    = {q_sr, q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : RUN;
         RUN:  if (last_step)    state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd         <= '0;
         q_sr        <= '0;
         dsr         <= '0;
         r           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         q_ovf       <= 1'b0;
      end else if (accept) begin
         dvd  <= bus.dividend;
         dsr  <= bus.divisor;
         r    <= '0;
         cnt  <= '0;
         // Divide-by-zero skips the iteration and publishes its result immediately.
         if (bus.divisor == '0) begin
            quotient    <= '1;
            remainder   <= bus.dividend[D_W-1:0];
            div_by_zero <= 1'b1;
            q_ovf       <= 1'b0;
         end
      end else if (state == RUN) begin
         dvd  <= {dvd[N_W-2:0], 1'b0};
         q_sr <= q_full[N_W-2:0];
         r    <= r_nxt;
         cnt  <= cnt + C_W'(1);
         if (last_step) begin
            quotient    <= q_full;
            remainder   <= r_nxt[D_W-1:0];
            div_by_zero <= 1'b0;
            q_ovf       <= |q_full[N_W-1:D_W];
         end
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.div_by_zero = div_by_zero;
   assign bus.q_ovf       = q_ovf;
endmodule
